trap_controller: RTL and testbench
==================================

# trap_controller

Machine-mode trap sequencer at the back end of the execute stage. Accepts the exception number/valid pair raised by execute units (ECALL = 11, EBREAK = 3, others), records the trap in mepc/mcause/mtval, and redirects fetch to mtvec. Also executes MRET returns, owns mstatus.MIE/MPIE, and serves those CSRs to the CSR execute unit.

## Interface
Parameters:
- XLEN, 32, register/PC width
- RESET_MTVEC, 32'h0000_0000, mtvec value after reset

Ports:
- clk  input  1  core clock
- reset_n  input  1  synchronous, active-low reset
- exception_valid_in  input  1  execute stage raising a trap this cycle
- exception_num_in  input  6  cause code (11 ECALL_M, 3 EBREAK, ...)
- exception_pc_in  input  XLEN  PC of the trapping instruction
- exception_tval_in  input  XLEN  trap value (0 for ECALL/EBREAK)
- mret_valid_in  input  1  MRET retiring this cycle
- csr_addr  input  12  CSR index
- csr_wr_en  input  1  CSR write strobe
- csr_wr_data  input  XLEN  CSR write data
- csr_rd_data  output  XLEN  combinational read of csr_addr; 0 if unmapped
- busy  output  1  high in any state except IDLE; execute stage must stall
- redirect_valid  output  1  fetch redirect request
- redirect_pc  output  XLEN  redirect target
- redirect_ready  input  1  fetch accepts redirect

## Operation
- Mapped CSRs: mstatus 0x300 (MIE bit 3, MPIE bit 7, rest read 0), mtvec 0x305, mepc 0x341, mcause 0x342, mtval 0x343.
- mtvec direct mode only: bits [1:0] written as 0. mepc bits [1:0] always 0.
- FSM states: IDLE, CAPTURE, REDIRECT.
- IDLE: exception_valid_in -> CAPTURE, latch num/pc/tval. Else mret_valid_in -> REDIRECT with target mepc, MIE<=MPIE, MPIE<=1. Exception wins over simultaneous MRET; MRET dropped.
- CAPTURE (1 cycle): mepc<=pc, mcause<={0, zero-extended num}, mtval<=tval, MPIE<=MIE, MIE<=0; target<=mtvec; -> REDIRECT.
- REDIRECT: redirect_valid=1, redirect_pc=target stable until redirect_ready sampled high; then -> IDLE.
- exception_valid_in / mret_valid_in ignored outside IDLE (pipeline is stalled by busy).
- CSR write same cycle as CAPTURE to mepc/mcause/mtval/mstatus: trap update wins; write to mtvec takes effect but target uses pre-write mtvec.
- CSR writes in IDLE apply at next edge; csr_rd_data reflects registered values.

## Timing
- Reset (reset_n low at clk edge): state IDLE, busy 0, redirect_valid 0, redirect_pc 0, mtvec RESET_MTVEC, mepc/mcause/mtval 0, MIE 0, MPIE 0. csr_rd_data follows reset values.
- Trap: edge N samples exception_valid_in; busy high from N+1; redirect_valid high from N+2. With redirect_ready tied high, IDLE at N+3.
- MRET: redirect_valid high from N+1; 1-cycle shorter than trap.
- Reset mid-REDIRECT aborts redirect; no CSR retains partial trap state beyond already-written values being cleared.
- Back-to-back: new trap accepted the cycle after return to IDLE.

## Configuration
- TRAP_IRQ_EN defined: adds input irq_in (1 bit, level). In IDLE with no exception_valid_in, no mret_valid_in, MIE=1 and irq_in=1: take interrupt via CAPTURE with mepc<=exception_pc_in, mcause<=32'h8000_000B, mtval<=0. Exceptions and MRET take priority.
- Not defined: no irq_in port, mcause bit 31 always 0, MIE affects only save/restore.

## Structure
- Shared package trap_pkg: CSR address constants, exception code constants (ECALL_M 11, EBREAK 3, M-external-IRQ 11), state enum, mstatus bit indices.
- Sub-module trap_csr_file: CSR registers, write-masking and read mux; FSM stays in trap_controller.

## Test plan
- ECALL at pc 0x100, mtvec 0x400, redirect_ready=1 -> mepc 0x100, mcause 11, mtval 0, redirect_pc 0x400 two cycles after request, busy 2 cycles... IDLE at N+3.
- EBREAK with redirect_ready low 5 cycles -> redirect_valid/redirect_pc held 5 cycles, mcause 3.
- MIE=1, trap then MRET -> after trap MIE 0 MPIE 1; after MRET redirect_pc=mepc, MIE 1, MPIE 1.
- Exception and MRET same cycle -> trap taken, mstatus not restored; second exception during busy ignored.
- CSR write mepc=0x203 -> reads 0x200; write mtvec=0x503 in IDLE -> reads 0x500; reset mid-REDIRECT -> all outputs reset values next cycle.
- TRAP_IRQ_EN, MIE=1, irq_in=1 -> mcause 0x8000000B, mepc=exception_pc_in; with MIE=0 no trap.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared constants and types for the machine-mode trap sequencer.
package trap_pkg;

  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMtvec   = 12'h305;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;
  localparam logic [11:0] CsrMtval   = 12'h343;

  localparam logic [5:0] ExcEcallM     = 6'd11;
  localparam logic [5:0] ExcBreakpoint = 6'd3;
  localparam logic [5:0] IrqMExt       = 6'd11;

  localparam int unsigned MstatusMieBit  = 3;
  localparam int unsigned MstatusMpieBit = 7;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StRedirect
  } trap_state_e;

endpackage

// File: rtl/trap_csr_file.sv
// Trap CSR storage (mstatus/mtvec/mepc/mcause/mtval), write masking and read mux.
// Trap capture takes priority over software writes to the trap-state CSRs.
module trap_csr_file
  import trap_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [11:0]     csr_addr_i,
  input  logic            csr_wr_en_i,
  input  logic [XLEN-1:0] csr_wr_data_i,
  input  logic            trap_we_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_tval_i,
  input  logic            mret_we_i,
  output logic [XLEN-1:0] csr_rd_data_o,
  output logic [XLEN-1:0] mtvec_o,
`ifdef TRAP_IRQ_EN
  output logic            mie_o,
`endif
  output logic [XLEN-1:0] mepc_o
);

  localparam logic [XLEN-1:0] AlignMask = ~XLEN'(3);

  logic [XLEN-1:0] mtvec_q, mepc_q, mcause_q, mtval_q;
  logic            mie_q, mpie_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mtvec_q  <= RESET_MTVEC;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
    end else begin
      // mtvec is never touched by trap entry, so a concurrent write always lands.
      if (csr_wr_en_i && csr_addr_i == CsrMtvec) mtvec_q <= csr_wr_data_i & AlignMask;
      if (trap_we_i) begin
        mepc_q   <= trap_pc_i & AlignMask;
        mcause_q <= trap_cause_i;
        mtval_q  <= trap_tval_i;
        mpie_q   <= mie_q;
        mie_q    <= 1'b0;
      end else begin
        if (csr_wr_en_i) begin
          case (csr_addr_i)
            CsrMepc:   mepc_q   <= csr_wr_data_i & AlignMask;
            CsrMcause: mcause_q <= csr_wr_data_i;
            CsrMtval:  mtval_q  <= csr_wr_data_i;
            CsrMstatus: begin
              if (!mret_we_i) begin
                mie_q  <= csr_wr_data_i[MstatusMieBit];
                mpie_q <= csr_wr_data_i[MstatusMpieBit];
              end
            end
            default: ;
          endcase
        end
        if (mret_we_i) begin
          mie_q  <= mpie_q;
          mpie_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    csr_rd_data_o = '0;
    case (csr_addr_i)
      CsrMstatus: begin
        csr_rd_data_o[MstatusMieBit]  = mie_q;
        csr_rd_data_o[MstatusMpieBit] = mpie_q;
      end
      CsrMtvec:  csr_rd_data_o = mtvec_q;
      CsrMepc:   csr_rd_data_o = mepc_q;
      CsrMcause: csr_rd_data_o = mcause_q;
      CsrMtval:  csr_rd_data_o = mtval_q;
      default:   csr_rd_data_o = '0;
    endcase
  end

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;
`ifdef TRAP_IRQ_EN
  assign mie_o   = mie_q;
`endif

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: IDLE -> CAPTURE -> REDIRECT for traps, IDLE -> REDIRECT for MRET.
// Define TRAP_IRQ_EN to add the level-sensitive irq_in machine external interrupt.
module trap_controller
  import trap_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            exception_valid_in,
  input  logic [5:0]      exception_num_in,
  input  logic [XLEN-1:0] exception_pc_in,
  input  logic [XLEN-1:0] exception_tval_in,
  input  logic            mret_valid_in,
`ifdef TRAP_IRQ_EN
  input  logic            irq_in,
`endif
  input  logic [11:0]     csr_addr,
  input  logic            csr_wr_en,
  input  logic [XLEN-1:0] csr_wr_data,
  output logic [XLEN-1:0] csr_rd_data,
  output logic            busy,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready
);

  trap_state_e     state_q;
  logic [5:0]      num_q;
  logic [XLEN-1:0] pc_q, tval_q, target_q;
  logic [XLEN-1:0] mtvec, mepc, trap_cause;
  logic            trap_we, mret_we;
`ifdef TRAP_IRQ_EN
  logic            mie;
  logic            irq_q;
`endif

  assign trap_we = (state_q == StCapture);
  assign mret_we = (state_q == StIdle) && !exception_valid_in && mret_valid_in;

  always_comb begin
    trap_cause = XLEN'(num_q);
`ifdef TRAP_IRQ_EN
    trap_cause[XLEN-1] = irq_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      num_q    <= '0;
      pc_q     <= '0;
      tval_q   <= '0;
      target_q <= '0;
`ifdef TRAP_IRQ_EN
      irq_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (exception_valid_in) begin
            num_q   <= exception_num_in;
            pc_q    <= exception_pc_in;
            tval_q  <= exception_tval_in;
`ifdef TRAP_IRQ_EN
            irq_q   <= 1'b0;
`endif
            state_q <= StCapture;
          end else if (mret_valid_in) begin
            target_q <= mepc;
            state_q  <= StRedirect;
          end
`ifdef TRAP_IRQ_EN
          else if (irq_in && mie) begin
            num_q   <= IrqMExt;
            pc_q    <= exception_pc_in;
            tval_q  <= '0;
            irq_q   <= 1'b1;
            state_q <= StCapture;
          end
`endif
        end
        // mtvec is sampled before any same-cycle CSR write reaches it.
        StCapture: begin
          target_q <= mtvec;
          state_q  <= StRedirect;
        end
        StRedirect: begin
          if (redirect_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy           = (state_q != StIdle);
  assign redirect_valid = (state_q == StRedirect);
  assign redirect_pc    = target_q;

  trap_csr_file #(
    .XLEN        (XLEN),
    .RESET_MTVEC (RESET_MTVEC)
  ) u_csr (
    .clk_i         (clk),
    .rst_ni        (reset_n),
    .csr_addr_i    (csr_addr),
    .csr_wr_en_i   (csr_wr_en),
    .csr_wr_data_i (csr_wr_data),
    .trap_we_i     (trap_we),
    .trap_pc_i     (pc_q),
    .trap_cause_i  (trap_cause),
    .trap_tval_i   (tval_q),
    .mret_we_i     (mret_we),
    .csr_rd_data_o (csr_rd_data),
    .mtvec_o       (mtvec),
`ifdef TRAP_IRQ_EN
    .mie_o         (mie),
`endif
    .mepc_o        (mepc)
  );

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller; redirect targets are checked by a scoreboard monitor.
module tb_trap_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        exception_valid_in;
  logic [5:0]  exception_num_in;
  logic [31:0] exception_pc_in, exception_tval_in;
  logic        mret_valid_in;
  logic [11:0] csr_addr;
  logic        csr_wr_en;
  logic [31:0] csr_wr_data, csr_rd_data;
  logic        busy, redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;
`ifdef TRAP_IRQ_EN
  logic        irq_in;
`endif

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  trap_controller #(
    .XLEN        (32),
    .RESET_MTVEC (32'h0000_0080)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .exception_valid_in (exception_valid_in),
    .exception_num_in   (exception_num_in),
    .exception_pc_in    (exception_pc_in),
    .exception_tval_in  (exception_tval_in),
    .mret_valid_in      (mret_valid_in),
`ifdef TRAP_IRQ_EN
    .irq_in             (irq_in),
`endif
    .csr_addr           (csr_addr),
    .csr_wr_en          (csr_wr_en),
    .csr_wr_data        (csr_wr_data),
    .csr_rd_data        (csr_rd_data),
    .busy               (busy),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .redirect_ready     (redirect_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every accepted redirect must match the oldest expected target.
  always @(negedge clk) begin
    if (reset_n && redirect_valid && redirect_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_redirect: got %h expected no redirect", redirect_pc);
      end else begin
        check("redirect_pc", redirect_pc, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input logic [11:0] addr, input logic [31:0] exp, input string name);
    csr_addr = addr;
    #1;
    check(name, csr_rd_data, exp);
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_wr_en   = 1'b1;
    csr_addr    = addr;
    csr_wr_data = data;
    tick();
    csr_wr_en   = 1'b0;
  endtask

  // Full trap with redirect_ready high; optional CSR write lands in the CAPTURE cycle.
  task automatic do_trap(input logic [5:0] num, input logic [31:0] pc, input logic [31:0] tval,
                         input logic [31:0] target, input logic cap_wr,
                         input logic [11:0] cap_addr, input logic [31:0] cap_data);
    exp_q.push_back(target);
    redirect_ready     = 1'b1;
    exception_valid_in = 1'b1;
    exception_num_in   = num;
    exception_pc_in    = pc;
    exception_tval_in  = tval;
    tick();
    exception_valid_in = 1'b0;
    check("busy_capture", {31'd0, busy}, 32'd1);
    check("rv_capture", {31'd0, redirect_valid}, 32'd0);
    csr_wr_en   = cap_wr;
    csr_addr    = cap_addr;
    csr_wr_data = cap_data;
    tick();
    csr_wr_en = 1'b0;
    check("rv_redirect", {31'd0, redirect_valid}, 32'd1);
    tick();
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    exception_valid_in = 1'b0; exception_num_in = '0;
    exception_pc_in = '0; exception_tval_in = '0;
    mret_valid_in = 1'b0; csr_addr = '0; csr_wr_en = 1'b0; csr_wr_data = '0;
    redirect_ready = 1'b1;
`ifdef TRAP_IRQ_EN
    irq_in = 1'b0;
`endif
    tick(); tick();
    reset_n = 1'b1;

    // Reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rv", {31'd0, redirect_valid}, 32'd0);
    check("rst_rpc", redirect_pc, 32'h0);
    rd_check(12'h305, 32'h80, "rst_mtvec");
    rd_check(12'h341, 32'h0, "rst_mepc");
    rd_check(12'h300, 32'h0, "rst_mstatus");
    rd_check(12'h344, 32'h0, "unmapped");
    tick();

    // CSR write masking
    csr_write(12'h305, 32'h503);
    rd_check(12'h305, 32'h500, "mtvec_mask");
    csr_write(12'h341, 32'h203);
    rd_check(12'h341, 32'h200, "mepc_mask");
    csr_write(12'h305, 32'h400);

    // ECALL
    do_trap(6'd11, 32'h100, 32'h0, 32'h400, 1'b0, 12'h0, 32'h0);
    rd_check(12'h341, 32'h100, "ecall_mepc");
    rd_check(12'h342, 32'd11, "ecall_mcause");
    rd_check(12'h343, 32'h0, "ecall_mtval");
    rd_check(12'h300, 32'h0, "ecall_mstatus");

    // EBREAK with fetch stalling redirect for 5 cycles; a new exception while busy is ignored
    tick();
    exp_q.push_back(32'h400);
    redirect_ready = 1'b0;
    exception_valid_in = 1'b1; exception_num_in = 6'd3;
    exception_pc_in = 32'h204; exception_tval_in = 32'h1234;
    tick();
    exception_valid_in = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("hold_rv", {31'd0, redirect_valid}, 32'd1);
      check("hold_rpc", redirect_pc, 32'h400);
      if (i == 0) begin
        exception_valid_in = 1'b1; exception_num_in = 6'd5; exception_pc_in = 32'h900;
      end
      tick();
    end
    exception_valid_in = 1'b0;
    redirect_ready = 1'b1;
    tick();
    check("ebreak_idle", {31'd0, busy}, 32'd0);
    rd_check(12'h342, 32'd3, "ebreak_mcause");
    rd_check(12'h341, 32'h204, "ebreak_mepc");
    rd_check(12'h343, 32'h1234, "ebreak_mtval");

    // MIE=1, trap then MRET
    csr_write(12'h300, 32'h8);
    rd_check(12'h300, 32'h8, "mie_set");
    do_trap(6'd11, 32'h300, 32'h0, 32'h400, 1'b0, 12'h0, 32'h0);
    rd_check(12'h300, 32'h80, "trap_mstatus");
    rd_check(12'h341, 32'h300, "trap2_mepc");
    exp_q.push_back(32'h300);
    mret_valid_in = 1'b1;
    tick();
    mret_valid_in = 1'b0;
    check("mret_rv", {31'd0, redirect_valid}, 32'd1);
    tick();
    check("mret_idle", {31'd0, busy}, 32'd0);
    rd_check(12'h300, 32'h88, "mret_mstatus");

    // Exception and MRET together: exception wins, no restore
    csr_write(12'h300, 32'h80);
    mret_valid_in = 1'b1;
    do_trap(6'd2, 32'h500, 32'h55, 32'h400, 1'b0, 12'h0, 32'h0);
    mret_valid_in = 1'b0;
    rd_check(12'h300, 32'h0, "both_mstatus");
    rd_check(12'h342, 32'd2, "both_mcause");
    rd_check(12'h341, 32'h500, "both_mepc");

    // CSR writes during CAPTURE, issued back-to-back
    do_trap(6'd4, 32'h600, 32'h0, 32'h400, 1'b1, 12'h305, 32'h600);
    do_trap(6'd7, 32'h700, 32'h0, 32'h600, 1'b1, 12'h342, 32'h77);
    rd_check(12'h305, 32'h600, "cap_mtvec");
    rd_check(12'h342, 32'd7, "cap_mcause");

`ifdef TRAP_IRQ_EN
    // Interrupt gated by MIE
    irq_in = 1'b1; exception_pc_in = 32'h800;
    tick(); tick();
    check("irq_masked", {31'd0, busy}, 32'd0);
    exp_q.push_back(32'h600);
    csr_write(12'h300, 32'h8);
    tick();
    irq_in = 1'b0;
    check("irq_busy", {31'd0, busy}, 32'd1);
    tick(); tick();
    rd_check(12'h342, 32'h8000_000B, "irq_mcause");
    rd_check(12'h341, 32'h800, "irq_mepc");
    rd_check(12'h343, 32'h0, "irq_mtval");
`endif

    // Reset while REDIRECT is waiting
    redirect_ready = 1'b0;
    exception_valid_in = 1'b1; exception_num_in = 6'd11;
    exception_pc_in = 32'h104; exception_tval_in = 32'h9;
    tick();
    exception_valid_in = 1'b0;
    tick();
    check("pre_rst_rv", {31'd0, redirect_valid}, 32'd1);
    reset_n = 1'b0;
    tick();
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_rv", {31'd0, redirect_valid}, 32'd0);
    check("mid_rst_rpc", redirect_pc, 32'h0);
    rd_check(12'h341, 32'h0, "mid_rst_mepc");
    rd_check(12'h305, 32'h80, "mid_rst_mtvec");
    rd_check(12'h342, 32'h0, "mid_rst_mcause");
    reset_n = 1'b1;
    redirect_ready = 1'b1;
    tick(); tick();

    check("sb_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
